// File: rtl/riscv_muldiv_pkg.sv
// Shared RISC-V M-extension definitions: funct3 encodings, muldiv FSM states
// and operand signedness helpers.
package riscv_muldiv_pkg;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic signedA(input logic [2:0] f);
        return (f == F3_MUL) || (f == F3_MULH) || (f == F3_MULHSU) ||
               (f == F3_DIV) || (f == F3_REM);
    endfunction

    function automatic logic signedB(input logic [2:0] f);
        return (f == F3_MUL) || (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
    endfunction

endpackage

// File: rtl/riscv_muldiv_if.sv
// Request/result handshake between the execute stage (master) and the muldiv unit (slave).
interface riscv_muldiv_if #(parameter int XLEN = 32);
    logic            i_valid;
    logic            o_ready;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_op_a;
    logic [XLEN-1:0] i_op_b;
    logic [4:0]      i_rd_addr;
    logic            i_flush;
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_result;
    logic [4:0]      o_rd_addr;
    logic            o_busy;

    modport master (
        output i_valid, i_funct3, i_op_a, i_op_b, i_rd_addr, i_flush, i_ready,
        input  o_ready, o_valid, o_result, o_rd_addr, o_busy
    );

    modport slave (
        input  i_valid, i_funct3, i_op_a, i_op_b, i_rd_addr, i_flush, i_ready,
        output o_ready, o_valid, o_result, o_rd_addr, o_busy
    );
endinterface

// File: rtl/riscv_muldiv_core.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide on a shared
// {hi, lo} register pair, STEPS radix-2 iterations per step cycle.
module riscv_muldiv_core #(
    parameter int XLEN  = 32,
    parameter int STEPS = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            load,
    input  logic            step,
    input  logic            isDiv,
    input  logic [XLEN-1:0] loInit,
    input  logic [XLEN-1:0] mInit,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    logic [XLEN-1:0] hiQ, loQ, mQ;
    logic            divQ;
    logic [XLEN-1:0] hiN, loN;
    logic [XLEN:0]   sum, sh, trial;

    // Multiply: lo holds the multiplier, product shifts in from the top.
    // Divide: lo holds the dividend, quotient bits shift in from the bottom.
    always_comb begin
        hiN   = hiQ;
        loN   = loQ;
        sum   = '0;
        sh    = '0;
        trial = '0;
        for (int s = 0; s < STEPS; s++) begin
            if (divQ) begin
                sh    = {hiN, loN[XLEN-1]};
                trial = sh - {1'b0, mQ};
                hiN   = trial[XLEN] ? sh[XLEN-1:0] : trial[XLEN-1:0];
                loN   = {loN[XLEN-2:0], ~trial[XLEN]};
            end else begin
                sum = {1'b0, hiN} + (loN[0] ? {1'b0, mQ} : '0);
                loN = {sum[0], loN[XLEN-1:1]};
                hiN = sum[XLEN:1];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hiQ  <= '0;
            loQ  <= '0;
            mQ   <= '0;
            divQ <= 1'b0;
        end else if (load) begin
            hiQ  <= '0;
            loQ  <= loInit;
            mQ   <= mInit;
            divQ <= isDiv;
        end else if (step) begin
            hiQ <= hiN;
            loQ <= loN;
        end
    end

    assign hi = hiQ;
    assign lo = loQ;

endmodule

// File: rtl/riscv_muldiv.sv
// RV M-extension multiply/divide unit: FSM, handshake, special-case detection and
// sign correction around the iterative core.
module riscv_muldiv
    import riscv_muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int STEPS = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    riscv_muldiv_if.slave   bus
);

    localparam int N  = XLEN / STEPS;
    localparam int CW = $clog2(N + 1);

    state_e          state, stateNext;
    logic [CW-1:0]   cnt;
    funct3_e         f3Q;
    logic [4:0]      rdQ;
    logic            negQ, specQ;
    logic [XLEN-1:0] specResQ;

    logic            accept, step, isDiv, signA, signB, divZero, ovf, negIn;
    logic [XLEN-1:0] magA, magB, specIn, coreHi, coreLo, quo, rem, res;
    logic [2*XLEN-1:0] prod;

    assign accept = bus.i_valid && (state == IDLE) && !bus.i_flush;
    assign step   = (state == CALC) && !specQ;

    // Operate on magnitudes; the sign is restored on the way out.
    always_comb begin
        isDiv   = bus.i_funct3[2];
        signA   = signedA(bus.i_funct3) && bus.i_op_a[XLEN-1];
        signB   = signedB(bus.i_funct3) && bus.i_op_b[XLEN-1];
        magA    = signA ? -bus.i_op_a : bus.i_op_a;
        magB    = signB ? -bus.i_op_b : bus.i_op_b;
        divZero = isDiv && (bus.i_op_b == '0);
        ovf     = isDiv && !bus.i_funct3[0] &&
                  (bus.i_op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.i_op_b == '1);
        negIn   = (isDiv && bus.i_funct3[1]) ? signA : (signA ^ signB);
        specIn  = '0;
        if (divZero)
            specIn = bus.i_funct3[1] ? bus.i_op_a : '1;
        else if (ovf)
            specIn = bus.i_funct3[1] ? '0 : bus.i_op_a;
    end

    riscv_muldiv_core #(.XLEN(XLEN), .STEPS(STEPS)) core (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .load   (accept),
        .step   (step),
        .isDiv  (isDiv),
        .loInit (isDiv ? magA : magB),
        .mInit  (isDiv ? magB : magA),
        .hi     (coreHi),
        .lo     (coreLo)
    );

    // Special cases spend a single CALC cycle, then go straight to DONE.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = CALC;
            CALC:    if (specQ || cnt == CW'(N - 1)) stateNext = DONE;
            DONE:    if (bus.i_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (bus.i_flush) stateNext = IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            f3Q      <= F3_MUL;
            rdQ      <= '0;
            negQ     <= 1'b0;
            specQ    <= 1'b0;
            specResQ <= '0;
        end else begin
            state <= stateNext;
            if (accept) begin
                cnt      <= '0;
                f3Q      <= funct3_e'(bus.i_funct3);
                rdQ      <= bus.i_rd_addr;
                negQ     <= negIn;
                specQ    <= divZero || ovf;
                specResQ <= specIn;
            end else if (step) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_comb begin
        prod = {coreHi, coreLo};
        if (negQ) prod = -prod;
        quo = negQ ? -coreLo : coreLo;
        rem = negQ ? -coreHi : coreHi;
        case (f3Q)
            F3_MUL:                       res = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: res = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              res = quo;
            default:                      res = rem;
        endcase
        if (specQ) res = specResQ;
    end

    assign bus.o_ready   = (state == IDLE);
    assign bus.o_busy    = (state != IDLE);
    assign bus.o_valid   = (state == DONE);
    assign bus.o_result  = (state == DONE) ? res : '0;
    assign bus.o_rd_addr = (state == DONE) ? rdQ : '0;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Bench for riscv_muldiv: directed table, random ops against an arithmetic model,
// stall/flush/reset sequences, for STEPS=1 and STEPS=4 instances.
module tb_riscv_muldiv;

    logic        clk = 1'b0;
    logic        rst, vld, flush, rdy, sel;
    logic [2:0]  f3;
    logic [31:0] opA, opB;
    logic [4:0]  rd;
    logic        oValid, oReady, oBusy;
    logic [31:0] oResult;
    logic [4:0]  oRdAddr;
    int          checks = 0;
    int          errors = 0;
    int          n;

    always #5 clk = ~clk;

    riscv_muldiv_if #(.XLEN(32)) b1 ();
    riscv_muldiv_if #(.XLEN(32)) b4 ();

    riscv_muldiv #(.XLEN(32), .STEPS(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(b1.slave));
    riscv_muldiv #(.XLEN(32), .STEPS(4)) dut4 (.i_clk(clk), .i_rst(rst), .bus(b4.slave));

    assign b1.i_valid = vld && !sel;
    assign b4.i_valid = vld && sel;
    assign b1.i_funct3 = f3;   assign b4.i_funct3 = f3;
    assign b1.i_op_a = opA;    assign b4.i_op_a = opA;
    assign b1.i_op_b = opB;    assign b4.i_op_b = opB;
    assign b1.i_rd_addr = rd;  assign b4.i_rd_addr = rd;
    assign b1.i_flush = flush; assign b4.i_flush = flush;
    assign b1.i_ready = rdy;   assign b4.i_ready = rdy;

    assign oValid  = sel ? b4.o_valid   : b1.o_valid;
    assign oReady  = sel ? b4.o_ready   : b1.o_ready;
    assign oBusy   = sel ? b4.o_busy    : b1.o_busy;
    assign oResult = sel ? b4.o_result  : b1.o_result;
    assign oRdAddr = sel ? b4.o_rd_addr : b1.o_rd_addr;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          spec;
        string       nm;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: RISC-V M semantics in plain 64-bit arithmetic.
    function automatic logic [31:0] refRes(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        logic [31:0] r;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r = '0;
        case (f)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = '1;
                else if (ovf) r = a;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (ovf) r = '0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int refLat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int iters);
        logic spec;
        spec = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        return spec ? 2 : iters + 1;
    endfunction

    // Starts at a negedge with the unit idle; ends at the negedge after consumption.
    task automatic doOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [31:0] expRes, input int expLat,
                        input int hold, input string nm);
        int cyc;
        vld = 1'b1; f3 = f; opA = a; opB = b; rd = tag;
        @(negedge clk);
        vld = 1'b0;
        if (hold > 0) rdy = 1'b0;
        cyc = 1;
        while (!oValid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("%s lat", nm), 32'(cyc), 32'(expLat));
        chk($sformatf("%s res", nm), oResult, expRes);
        chk($sformatf("%s tag", nm), 32'(oRdAddr), 32'(tag));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk($sformatf("%s hold valid", nm), 32'(oValid), 32'd1);
            chk($sformatf("%s hold res", nm), oResult, expRes);
            chk($sformatf("%s hold tag", nm), 32'(oRdAddr), 32'(tag));
        end
        rdy = 1'b1;
        @(negedge clk);
        chk($sformatf("%s consumed", nm), {30'b0, oValid, oReady}, 32'b01);
    endtask

    task automatic resetPulse(input string nm);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk($sformatf("%s busy", nm), 32'(oBusy), 32'd0);
        chk($sformatf("%s valid", nm), 32'(oValid), 32'd0);
        chk($sformatf("%s res", nm), oResult, 32'd0);
        chk($sformatf("%s tag", nm), 32'(oRdAddr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk($sformatf("%s ready", nm), 32'(oReady), 32'd1);
    endtask

    initial begin
        tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul"};
        tbl[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mulhu"};
        tbl[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "mulh"};
        tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhsu"};
        tbl[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, "div"};
        tbl[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, "rem"};
        tbl[6]  = '{3'd5, 32'd100,       32'd0,         32'hFFFF_FFFF, 1'b1, "divu0"};
        tbl[7]  = '{3'd7, 32'd100,       32'd0,         32'd100,       1'b1, "remu0"};
        tbl[8]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "divovf"};
        tbl[9]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "removf"};
        tbl[10] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "divubig"};
        tbl[11] = '{3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b1, "rem0"};

        rst = 1'b1; vld = 1'b0; flush = 1'b0; rdy = 1'b1; sel = 1'b0;
        f3 = '0; opA = '0; opB = '0; rd = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            n   = s ? 8 : 32;
            resetPulse($sformatf("s%0d reset", s));

            // Flush wins over a simultaneous request.
            vld = 1'b1; flush = 1'b1; f3 = 3'd0; opA = 32'd3; opB = 32'd4;
            @(negedge clk);
            vld = 1'b0; flush = 1'b0;
            chk($sformatf("s%0d flushreq busy", s), 32'(oBusy), 32'd0);

            for (int i = 0; i < 12; i++)
                doOp(tbl[i].f3, tbl[i].a, tbl[i].b, 5'(i + 1), tbl[i].res,
                     tbl[i].spec ? 2 : n + 1, 0, $sformatf("s%0d %s", s, tbl[i].nm));

            for (int i = 0; i < 30; i++) begin
                logic [2:0]  rf;
                logic [31:0] ra, rb;
                int          pick;
                rf = 3'($urandom_range(0, 7));
                ra = $urandom;
                rb = $urandom;
                pick = int'($urandom_range(0, 9));
                if (pick == 0) rb = '0;
                if (pick == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                if (pick == 2) begin ra = 32'($urandom_range(0, 200)); rb = 32'($urandom_range(1, 20)); end
                if (pick == 3) rb = -32'($urandom_range(1, 20));
                doOp(rf, ra, rb, 5'($urandom_range(0, 31)), refRes(rf, ra, rb),
                     refLat(rf, ra, rb, n), 0, $sformatf("s%0d rnd%0d f%0d", s, i, rf));
            end

            doOp(3'd0, 32'd123, 32'd456, 5'd9, 32'd56088, n + 1, 5, $sformatf("s%0d stall", s));

            // Flush part-way through CALC.
            vld = 1'b1; f3 = 3'd0; opA = 32'd11; opB = 32'd13; rd = 5'd3;
            @(negedge clk);
            vld = 1'b0;
            repeat ((n > 10 ? 10 : n / 2) - 1) @(negedge clk);
            chk($sformatf("s%0d flush pre busy", s), 32'(oBusy), 32'd1);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            chk($sformatf("s%0d flush state", s), {29'b0, oValid, oReady, oBusy}, 32'b010);
            repeat (n + 2) @(negedge clk);
            chk($sformatf("s%0d flush nores", s), 32'(oValid), 32'd0);
            doOp(3'd4, 32'd1000, 32'd7, 5'd17, 32'd142, n + 1, 0, $sformatf("s%0d postflush", s));

            // Reset part-way through CALC.
            vld = 1'b1; f3 = 3'd5; opA = 32'd999; opB = 32'd10; rd = 5'd4;
            @(negedge clk);
            vld = 1'b0;
            repeat (3) @(negedge clk);
            chk($sformatf("s%0d midcalc busy", s), 32'(oBusy), 32'd1);
            resetPulse($sformatf("s%0d midrst", s));
            doOp(3'd7, 32'd999, 32'd10, 5'd21, 32'd9, n + 1, 0, $sformatf("s%0d postrst", s));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
